// File: rtl/fc_sched_pkg.sv
// fc_sched_pkg
//   Shared definitions for the fully-connected layer sequencer:
//   - state_t    : sequencer FSM states
//   - ceil_div   : chunk count for a layer input length
//   - clog2_min1 : address width, never narrower than one bit
package fc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT_RDY,
    DRAIN,
    DONE
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fc_muladd_sched_delay.sv
// ctrl_delay_line
//   Fixed-depth shift register for datapath control strobes, cleared by a
//   synchronous active-high reset so no stale strobe survives a reset.
//   Ports:
//     clk, rst : clock, synchronous active-high reset
//     i_d      : strobe bundle entering the line
//     o_q      : the same bundle DEPTH cycles later
module ctrl_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_tap [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_tap[i] <= '0;
    end else begin
      r_tap[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_tap[i] <= r_tap[i-1];
    end
  end

  assign o_q = r_tap[DEPTH-1];

endmodule

// File: rtl/fc_muladd_sched.sv
// fc_muladd_sched
//   Walks every output-neuron group over every CPF-wide input chunk of one
//   fully-connected layer, issuing buffer read addresses and the datapath
//   enable / end-of-group strobes, then flags each finished group result.
//   Ports:
//     clk, rst               : clock, synchronous active-high reset
//     start                  : one-cycle layer start (ignored while busy)
//     out_ready              : room downstream for one more group result,
//                              sampled only on the last beat of a group
//     busy, done             : layer in progress / one-cycle completion pulse
//     rd_en                  : buffer read strobe
//     in_addr, w_addr        : input chunk and weight row addresses
//     bias_addr              : bias address, constant across a group
//     op_din_en, op_din_eop  : datapath enable / end-of-group, RD_LAT late
//     dout_valid, dout_addr  : datapath result valid and its group index
module fc_muladd_sched
  import fc_sched_pkg::*;
#(
  parameter int CPF          = 4,
  parameter int IN_CH        = 16,
  parameter int OUT_CH       = 3,
  parameter int DATA_CHANNEL = 1,
  parameter int RD_LAT       = 1,
  parameter int DP_LAT       = 4,
  localparam int K  = ceil_div(IN_CH, CPF),
  localparam int G  = OUT_CH / DATA_CHANNEL,
  localparam int KW = clog2_min1(K),
  localparam int WW = clog2_min1(G * K),
  localparam int GW = clog2_min1(G)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [KW-1:0] in_addr,
  output logic [WW-1:0] w_addr,
  output logic [GW-1:0] bias_addr,
  output logic          op_din_en,
  output logic          op_din_eop,
  output logic          dout_valid,
  output logic [GW-1:0] dout_addr
);

  if (OUT_CH % DATA_CHANNEL != 0) begin : g_err_ch
    $error("OUT_CH must be a multiple of DATA_CHANNEL");
  end
  if (RD_LAT < 1) begin : g_err_rd
    $error("RD_LAT must be at least 1");
  end
  if (DP_LAT < 1) begin : g_err_dp
    $error("DP_LAT must be at least 1");
  end

  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  state_t        r_state;
  state_t        w_nxt;
  logic [KW-1:0] r_chunk;
  logic [GW-1:0] r_grp;
  logic [WW-1:0] r_w;
  logic [GW-1:0] r_dcnt;
  logic          w_rd_en;
  logic          w_last;
  logic          w_final;

  assign w_last  = (r_state == RUN) && (r_chunk == K_LAST);
  assign w_final = w_last && (r_grp == G_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:     if (start) w_nxt = RUN;
      RUN: begin
        // out_ready only matters on a group's last beat; otherwise the next
        // group's first beat follows with no bubble.
        if (w_final)                 w_nxt = DRAIN;
        else if (w_last && !out_ready) w_nxt = WAIT_RDY;
      end
      WAIT_RDY: if (out_ready) w_nxt = RUN;
      // The final result leaving the valid line means both delay lines are
      // empty, so that is the point the layer is complete.
      DRAIN:    if (dout_valid && (r_dcnt == G_LAST)) w_nxt = DONE;
      DONE:     w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_rd_en = (r_state == RUN);
    busy    = (r_state != IDLE);
    done    = (r_state == DONE);
  end

  // Address and result counters; start is honoured only from IDLE so a
  // repeated start mid-layer leaves every counter untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chunk <= '0;
      r_grp   <= '0;
      r_w     <= '0;
      r_dcnt  <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_chunk <= '0;
      r_grp   <= '0;
      r_w     <= '0;
      r_dcnt  <= '0;
    end else begin
      if (w_rd_en) begin
        if (!w_final) r_w <= r_w + 1'b1;
        if (w_last) begin
          r_chunk <= '0;
          if (!w_final) r_grp <= r_grp + 1'b1;
        end else begin
          r_chunk <= r_chunk + 1'b1;
        end
      end
      if (dout_valid && (r_dcnt != G_LAST)) r_dcnt <= r_dcnt + 1'b1;
    end
  end

  assign rd_en     = w_rd_en;
  assign in_addr   = r_chunk;
  assign w_addr    = r_w;
  assign bias_addr = r_grp;
  assign dout_addr = r_dcnt;

  // Read strobe and last-chunk flag travel together through the buffer
  // latency, so eop lands on the beat that also carries the bias word.
  ctrl_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_rd_dly (
    .clk (clk),
    .rst (rst),
    .i_d ({w_rd_en, w_last}),
    .o_q ({op_din_en, op_din_eop})
  );

  ctrl_delay_line #(
    .DEPTH (DP_LAT),
    .WIDTH (1)
  ) u_dp_dly (
    .clk (clk),
    .rst (rst),
    .i_d (op_din_eop),
    .o_q (dout_valid)
  );

endmodule

// File: tb/tb_fc_muladd_sched.sv
// tb_fc_muladd_sched
//   Scoreboard bench for fc_muladd_sched. Three instances cover the default
//   layer (K=4, G=3), a single-chunk layer (K=1, G=2) and an 8-bit-mode
//   layer (DATA_CHANNEL=2, K=2, G=2). Expected beats, eops, results, done
//   pulses and status samples are queued per instance with cycle numbers
//   relative to the start cycle; a negedge monitor pops and compares.
module tb_fc_muladd_sched;

  localparam int NI = 3;
  localparam int P_IN  [NI] = '{16, 4, 8};
  localparam int P_OUT [NI] = '{3, 2, 4};
  localparam int P_DC  [NI] = '{1, 1, 2};

  typedef struct { int t; int ia; int wa; int ba; } rd_t;
  typedef struct { int t; int eop; } en_t;
  typedef struct { int t; int a; } dv_t;
  typedef struct { int t; int kind; } st_t;  // kind 0: all outputs 0, 1: busy, 2: not busy

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0] rst_v, start_v, rdy_v;
  logic [NI-1:0] busy_v, done_v, rd_v, en_v, eop_v, dv_v;
  logic [7:0]    in_a [NI];
  logic [7:0]    w_a  [NI];
  logic [7:0]    b_a  [NI];
  logic [7:0]    d_a  [NI];

  rd_t q_rd [NI][$];
  en_t q_en [NI][$];
  dv_t q_dv [NI][$];
  int  q_dn [NI][$];
  st_t q_st [NI][$];
  int  base [NI];

  int total = 0;
  int bad   = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int K  = fc_sched_pkg::ceil_div(P_IN[gi], 4);
    localparam int G  = P_OUT[gi] / P_DC[gi];
    localparam int KW = fc_sched_pkg::clog2_min1(K);
    localparam int WW = fc_sched_pkg::clog2_min1(G * K);
    localparam int GW = fc_sched_pkg::clog2_min1(G);
    logic [KW-1:0] in_w;
    logic [WW-1:0] w_w;
    logic [GW-1:0] b_w;
    logic [GW-1:0] d_w;

    fc_muladd_sched #(
      .CPF          (4),
      .IN_CH        (P_IN[gi]),
      .OUT_CH       (P_OUT[gi]),
      .DATA_CHANNEL (P_DC[gi]),
      .RD_LAT       (1),
      .DP_LAT       (4)
    ) u_dut (
      .clk        (clk),
      .rst        (rst_v[gi]),
      .start      (start_v[gi]),
      .out_ready  (rdy_v[gi]),
      .busy       (busy_v[gi]),
      .done       (done_v[gi]),
      .rd_en      (rd_v[gi]),
      .in_addr    (in_w),
      .w_addr     (w_w),
      .bias_addr  (b_w),
      .op_din_en  (en_v[gi]),
      .op_din_eop (eop_v[gi]),
      .dout_valid (dv_v[gi]),
      .dout_addr  (d_w)
    );

    assign in_a[gi] = 8'(in_w);
    assign w_a[gi]  = 8'(w_w);
    assign b_a[gi]  = 8'(b_w);
    assign d_a[gi]  = 8'(d_w);
  end

  // Monitor: compares every DUT event against the front of its queue and
  // flags any expectation whose cycle has passed unserved.
  always @(negedge clk) begin : mon
    int  rel;
    rd_t r;
    en_t e;
    dv_t d;
    st_t s;
    int  tdn;
    logic any_out;
    for (int g = 0; g < NI; g++) begin
      rel = cyc - base[g];
      if (rd_v[g] === 1'b1) begin
        total++;
        if (q_rd[g].size() == 0) begin
          bad++;
          $display("FAIL rd_extra inst%0d t=%0d got w_addr=%0d, required no beat", g, rel, w_a[g]);
        end else begin
          r = q_rd[g].pop_front();
          if (r.t != rel || r.ia != int'(in_a[g]) || r.wa != int'(w_a[g]) || r.ba != int'(b_a[g])) begin
            bad++;
            $display("FAIL rd_beat inst%0d got t=%0d in=%0d w=%0d bias=%0d required t=%0d in=%0d w=%0d bias=%0d",
                     g, rel, in_a[g], w_a[g], b_a[g], r.t, r.ia, r.wa, r.ba);
          end
        end
      end
      if (en_v[g] === 1'b1) begin
        total++;
        if (q_en[g].size() == 0) begin
          bad++;
          $display("FAIL en_extra inst%0d t=%0d got op_din_en=1, required 0", g, rel);
        end else begin
          e = q_en[g].pop_front();
          if (e.t != rel || e.eop != int'(eop_v[g])) begin
            bad++;
            $display("FAIL en_beat inst%0d got t=%0d eop=%0d required t=%0d eop=%0d", g, rel, eop_v[g], e.t, e.eop);
          end
        end
      end
      if (eop_v[g] === 1'b1) begin
        total++;
        if (en_v[g] !== 1'b1) begin
          bad++;
          $display("FAIL eop_alone inst%0d t=%0d got op_din_en=%b, required 1", g, rel, en_v[g]);
        end
      end
      if (dv_v[g] === 1'b1) begin
        total++;
        if (q_dv[g].size() == 0) begin
          bad++;
          $display("FAIL dv_extra inst%0d t=%0d got dout_addr=%0d, required no result", g, rel, d_a[g]);
        end else begin
          d = q_dv[g].pop_front();
          if (d.t != rel || d.a != int'(d_a[g])) begin
            bad++;
            $display("FAIL dout inst%0d got t=%0d addr=%0d required t=%0d addr=%0d", g, rel, d_a[g], d.t, d.a);
          end
        end
      end
      if (done_v[g] === 1'b1) begin
        total++;
        if (q_dn[g].size() == 0) begin
          bad++;
          $display("FAIL done_extra inst%0d t=%0d got done=1, required 0", g, rel);
        end else begin
          tdn = q_dn[g].pop_front();
          if (tdn != rel) begin
            bad++;
            $display("FAIL done_time inst%0d got t=%0d required t=%0d", g, rel, tdn);
          end
        end
      end
      while (q_rd[g].size() > 0 && q_rd[g][0].t < rel) begin
        r = q_rd[g].pop_front();
        total++; bad++;
        $display("FAIL rd_missing inst%0d got none required t=%0d w=%0d", g, r.t, r.wa);
      end
      while (q_en[g].size() > 0 && q_en[g][0].t < rel) begin
        e = q_en[g].pop_front();
        total++; bad++;
        $display("FAIL en_missing inst%0d got none required t=%0d eop=%0d", g, e.t, e.eop);
      end
      while (q_dv[g].size() > 0 && q_dv[g][0].t < rel) begin
        d = q_dv[g].pop_front();
        total++; bad++;
        $display("FAIL dout_missing inst%0d got none required t=%0d addr=%0d", g, d.t, d.a);
      end
      while (q_dn[g].size() > 0 && q_dn[g][0] < rel) begin
        tdn = q_dn[g].pop_front();
        total++; bad++;
        $display("FAIL done_missing inst%0d got none required t=%0d", g, tdn);
      end
      while (q_st[g].size() > 0 && q_st[g][0].t <= rel) begin
        s = q_st[g].pop_front();
        total++;
        any_out = busy_v[g] | done_v[g] | rd_v[g] | en_v[g] | eop_v[g] | dv_v[g] |
                  (|in_a[g]) | (|w_a[g]) | (|b_a[g]) | (|d_a[g]);
        if (s.t < rel) begin
          bad++;
          $display("FAIL status_missed inst%0d got t=%0d required t=%0d", g, rel, s.t);
        end else if (s.kind == 0 && any_out !== 1'b0) begin
          bad++;
          $display("FAIL reset_state inst%0d t=%0d got busy=%b done=%b rd=%b en=%b eop=%b dv=%b in=%0d w=%0d b=%0d d=%0d required all 0",
                   g, rel, busy_v[g], done_v[g], rd_v[g], en_v[g], eop_v[g], dv_v[g], in_a[g], w_a[g], b_a[g], d_a[g]);
        end else if (s.kind == 1 && busy_v[g] !== 1'b1) begin
          bad++;
          $display("FAIL busy_high inst%0d t=%0d got busy=%b required 1", g, rel, busy_v[g]);
        end else if (s.kind == 2 && busy_v[g] !== 1'b0) begin
          bad++;
          $display("FAIL busy_low inst%0d t=%0d got busy=%b required 0", g, rel, busy_v[g]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st(input int g, input int t, input int kind);
    st_t s;
    s.t = t;
    s.kind = kind;
    q_st[g].push_back(s);
  endtask

  // Expected schedule with RD_LAT=1, DP_LAT=4: beats from cycle 1, eop one
  // cycle after a group's last beat, result five cycles after it. stall_len
  // extra cycles follow group 0; events at or after cut are not expected.
  task automatic push_layer(input int g, input int gn, input int kn, input int stall_len,
                            input int cut, input int done_t);
    rd_t r;
    en_t e;
    dv_t d;
    int  t = 1;
    int  w = 0;
    push_st(g, 1, 1);
    for (int gr = 0; gr < gn; gr++) begin
      for (int c = 0; c < kn; c++) begin
        if (t < cut) begin
          r.t = t; r.ia = c; r.wa = w; r.ba = gr;
          q_rd[g].push_back(r);
        end
        if (t + 1 < cut) begin
          e.t = t + 1; e.eop = (c == kn - 1) ? 1 : 0;
          q_en[g].push_back(e);
        end
        if (c == kn - 1 && t + 5 < cut) begin
          d.t = t + 5; d.a = gr;
          q_dv[g].push_back(d);
        end
        t++;
        w++;
      end
      if (gr == 0) t += stall_len;
    end
    if (done_t >= 0) begin
      q_dn[g].push_back(done_t);
      push_st(g, done_t, 1);
      push_st(g, done_t + 1, 2);
    end
  endtask

  // Cycle 0 of a scenario is the cycle in which start is first high.
  task automatic run_scn(input int g, input int rdy_lo, input int rdy_hi, input int rs1,
                         input int rs2, input int rst_at, input int ncyc);
    for (int r = 0; r < ncyc; r++) begin
      start_v[g] = (r == 0) || (r == rs1) || (r == rs2);
      rdy_v[g]   = !((r >= rdy_lo) && (r <= rdy_hi));
      rst_v[g]   = (r == rst_at);
      step();
    end
    start_v[g] = 1'b0;
    rdy_v[g]   = 1'b1;
    rst_v[g]   = 1'b0;
  endtask

  initial begin
    rst_v   = '1;
    start_v = '0;
    rdy_v   = '1;
    for (int g = 0; g < NI; g++) base[g] = 0;
    step();
    for (int g = 0; g < NI; g++) begin
      base[g] = cyc;
      push_st(g, 0, 0);
      push_st(g, 1, 0);
    end
    step();
    step();
    rst_v = '0;
    step();

    // Default layer: 12 beats, results at 9/13/17, done at 18
    base[0] = cyc;
    push_layer(0, 3, 4, 0, 1000, 18);
    run_scn(0, -10, -10, -1, -1, -1, 24);

    // Same layer with start re-pulsed at cycles 3 and 10
    base[0] = cyc;
    push_layer(0, 3, 4, 0, 1000, 18);
    run_scn(0, -10, -10, 3, 10, -1, 24);

    // out_ready low in cycles 3-6: beat 5 slips from cycle 5 to cycle 8
    base[0] = cyc;
    push_layer(0, 3, 4, 3, 1000, 21);
    run_scn(0, 3, 6, -1, -1, -1, 27);

    // rst in cycle 6: only events before cycle 7, all outputs 0 afterwards
    base[0] = cyc;
    push_layer(0, 3, 4, 0, 7, -1);
    for (int t = 7; t < 28; t++) push_st(0, t, 0);
    run_scn(0, -10, -10, -1, -1, 6, 30);

    // Fresh start after the reset runs normally
    base[0] = cyc;
    push_layer(0, 3, 4, 0, 1000, 18);
    run_scn(0, -10, -10, -1, -1, -1, 24);

    // K=1, G=2: every beat is eop, results at 6/7, done at 8
    base[1] = cyc;
    push_layer(1, 2, 1, 0, 1000, 8);
    run_scn(1, -10, -10, -1, -1, -1, 14);

    // DATA_CHANNEL=2: G=2, K=2, w_addr 0..3, results at 7/9, done at 10
    base[2] = cyc;
    push_layer(2, 2, 2, 0, 1000, 10);
    run_scn(2, -10, -10, -1, -1, -1, 16);

    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
